mem_spi_flash_responder: RTL and testbench

Synthesizable QSPI flash responder: the memory-device end of the SPI link driven by `mem_spi_controller`. It oversamples CS/SCLK/IO[3:0] on the system clock, decodes a W25Q-style command subset in single and quad mode, and serves reads and page programs from an external byte-wide memory port. It is used as the on-chip flash model in the memory-interface testbench and in loopback configurations of the top level.

---
 rtl/mem_flash_pkg.sv | 43 ++++
 rtl/mem_spi_sync_edge.sv | 33 +++
 rtl/mem_spi_flash_responder.sv | 214 +++++++++++++++++++++
 tb/tb_mem_spi_flash_responder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_flash_pkg.sv
// Shared constants for the QSPI flash responder: opcodes, FSM state codes
// and status-register bit positions.
package mem_flash_pkg;

    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_WRDI  = 8'h04;
    localparam logic [7:0] OP_RDSR1 = 8'h05;
    localparam logic [7:0] OP_RDSR2 = 8'h35;
    localparam logic [7:0] OP_WRSR2 = 8'h31;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_QREAD = 8'h6B;
    localparam logic [7:0] OP_PP    = 8'h02;
    localparam logic [7:0] OP_QPP   = 8'h32;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CMD    = 3'd1;
    localparam logic [2:0] ST_ADDR   = 3'd2;
    localparam logic [2:0] ST_DUMMY  = 3'd3;
    localparam logic [2:0] ST_RDATA  = 3'd4;
    localparam logic [2:0] ST_WDATA  = 3'd5;
    localparam logic [2:0] ST_STAT   = 3'd6;
    localparam logic [2:0] ST_IGNORE = 3'd7;

    localparam int SR1_BUSY_BIT = 0;
    localparam int SR1_WEL_BIT  = 1;
    localparam int SR2_QE_BIT   = 1;
    localparam int STATUS_WEL   = 0;
    localparam int STATUS_QE    = 1;

    // BUSY never sets: program completes within the write strobe.
    function automatic logic [7:0] status_byte(input logic [7:0] op,
                                               input logic qe,
                                               input logic wel);
        logic [7:0] sr;
        sr = 8'h00;
        if (op == OP_RDSR2)
            sr[SR2_QE_BIT] = qe;
        else
            sr[SR1_WEL_BIT] = wel;
        return sr;
    endfunction

endpackage

// File: rtl/mem_spi_sync_edge.sv
// Two-flop synchronizer with registered rise/fall pulses; a pin change
// shows up as a one-clock pulse three clocks later.
module mem_spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            sync <= RESET_VAL;
            prev <= RESET_VAL;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            meta <= d;
            sync <= meta;
            prev <= sync;
            rise <= sync & ~prev;
            fall <= ~sync & prev;
        end
    end

endmodule

// File: rtl/mem_spi_flash_responder.sv
// QSPI flash device model: oversamples the SPI pins, decodes a W25Q-style
// command subset and serves reads / page programs from a byte-wide memory.
module mem_spi_flash_responder
    import mem_flash_pkg::*;
#(
    parameter int ADDR_W     = 24,
    parameter int DUMMY_QUAD = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_cs_n,
    input  logic              in_sclk,
    input  logic [3:0]        in_io,
    output logic [3:0]        out_io,
    output logic [3:0]        out_io_oe,
    output logic [ADDR_W-1:0] out_mem_addr,
    output logic              out_mem_re,
    input  logic [7:0]        in_mem_rdata,
    output logic              out_mem_we,
    output logic [7:0]        out_mem_wdata,
    output logic [1:0]        out_status
);

    localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_QUAD - 1);

    logic cs_rise, cs_fall, sclk_rise, sclk_fall;
    logic [3:0] io_meta, io_sync;

    logic [2:0]  state;
    logic [7:0]  opcode;
    logic [7:0]  shift_in, shift_out, next_byte;
    logic [2:0]  in_cnt, out_cnt;
    logic [4:0]  addr_bits;
    logic [23:0] addr_sr;
    logic [7:0]  dummy_cnt;
    logic        quad, wel, qe, data_seen, re_pending;

    logic        in_quad, quad_out, byte_done;
    logic [7:0]  byte_in, src_byte;
    logic [23:0] addr_full;

    mem_spi_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
        .clk(clk), .rst(rst), .d(in_cs_n), .rise(cs_rise), .fall(cs_fall)
    );

    mem_spi_sync_edge #(.RESET_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .rst(rst), .d(in_sclk), .rise(sclk_rise), .fall(sclk_fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            io_meta <= 4'h0;
            io_sync <= 4'h0;
        end else begin
            io_meta <= in_io;
            io_sync <= io_meta;
        end
    end

    // Opcode and address are always single-bit; only data phases go quad.
    always_comb begin
        in_quad   = quad && (state == ST_WDATA);
        quad_out  = quad && (state == ST_RDATA);
        byte_in   = in_quad ? {shift_in[3:0], io_sync} : {shift_in[6:0], io_sync[0]};
        byte_done = in_quad ? (in_cnt == 3'd4) : (in_cnt == 3'd7);
        addr_full = {addr_sr[22:0], io_sync[0]};
        src_byte  = (state == ST_STAT) ? status_byte(opcode, qe, wel) : next_byte;
    end

    assign out_status = {qe, wel};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            opcode        <= 8'h00;
            shift_in      <= 8'h00;
            shift_out     <= 8'h00;
            next_byte     <= 8'h00;
            in_cnt        <= 3'd0;
            out_cnt       <= 3'd0;
            addr_bits     <= 5'd0;
            addr_sr       <= 24'h0;
            dummy_cnt     <= 8'h00;
            quad          <= 1'b0;
            wel           <= 1'b0;
            qe            <= 1'b0;
            data_seen     <= 1'b0;
            re_pending    <= 1'b0;
            out_io        <= 4'h0;
            out_io_oe     <= 4'h0;
            out_mem_addr  <= '0;
            out_mem_re    <= 1'b0;
            out_mem_we    <= 1'b0;
            out_mem_wdata <= 8'h00;
        end else begin
            out_mem_re <= 1'b0;
            out_mem_we <= 1'b0;
            re_pending <= out_mem_re;
            if (re_pending)
                next_byte <= in_mem_rdata;
            // Page program wraps inside the 256-byte page.
            if (out_mem_we)
                out_mem_addr[7:0] <= out_mem_addr[7:0] + 8'd1;

            if (cs_rise) begin
                state     <= ST_IDLE;
                out_io_oe <= 4'h0;
                data_seen <= 1'b0;
                if (data_seen)
                    wel <= 1'b0;
            end else if (cs_fall) begin
                state     <= ST_CMD;
                in_cnt    <= 3'd0;
                out_cnt   <= 3'd0;
                addr_bits <= 5'd0;
                dummy_cnt <= 8'h00;
                shift_in  <= 8'h00;
                out_io_oe <= 4'h0;
            end else if (sclk_rise && state != ST_IDLE) begin
                shift_in <= byte_in;
                in_cnt   <= in_cnt + (in_quad ? 3'd4 : 3'd1);
                case (state)
                    ST_CMD: begin
                        if (byte_done) begin
                            opcode <= byte_in;
                            quad   <= 1'b0;
                            case (byte_in)
                                OP_WREN: begin
                                    wel   <= 1'b1;
                                    state <= ST_IGNORE;
                                end
                                OP_WRDI: begin
                                    wel   <= 1'b0;
                                    state <= ST_IGNORE;
                                end
                                OP_RDSR1, OP_RDSR2: state <= ST_STAT;
                                OP_WRSR2:           state <= ST_WDATA;
                                OP_READ, OP_PP:     state <= ST_ADDR;
                                OP_QREAD, OP_QPP: begin
                                    quad  <= qe;
                                    state <= qe ? ST_ADDR : ST_IGNORE;
                                end
                                default: state <= ST_IGNORE;
                            endcase
                        end
                    end
                    ST_ADDR: begin
                        addr_sr   <= addr_full;
                        addr_bits <= addr_bits + 5'd1;
                        if (addr_bits == 5'd23) begin
                            out_mem_addr <= addr_full[ADDR_W-1:0];
                            if (opcode == OP_READ || opcode == OP_QREAD) begin
                                out_mem_re <= 1'b1;
                                state      <= (opcode == OP_QREAD) ? ST_DUMMY : ST_RDATA;
                            end else begin
                                state <= ST_WDATA;
                            end
                        end
                    end
                    ST_DUMMY: begin
                        dummy_cnt <= dummy_cnt + 8'd1;
                        if (dummy_cnt == DUMMY_LAST)
                            state <= ST_RDATA;
                    end
                    ST_WDATA: begin
                        if (byte_done) begin
                            data_seen <= 1'b1;
                            if (opcode == OP_WRSR2) begin
                                if (wel)
                                    qe <= byte_in[1];
                                state <= ST_IGNORE;
                            end else if (wel) begin
                                out_mem_we    <= 1'b1;
                                out_mem_wdata <= byte_in;
                            end
                        end
                    end
                    default: ;
                endcase
            end else if (sclk_fall && (state == ST_RDATA || state == ST_STAT)) begin
                // The next byte is fetched during the current one's last bits.
                if (quad_out) begin
                    out_io_oe <= 4'hF;
                    if (out_cnt[0] == 1'b0) begin
                        out_io       <= src_byte[7:4];
                        shift_out    <= {src_byte[3:0], 4'h0};
                        out_mem_addr <= out_mem_addr + 1'b1;
                        out_mem_re   <= 1'b1;
                        out_cnt      <= 3'd1;
                    end else begin
                        out_io    <= shift_out[7:4];
                        shift_out <= {shift_out[3:0], 4'h0};
                        out_cnt   <= 3'd0;
                    end
                end else begin
                    out_io_oe <= 4'b0010;
                    if (out_cnt == 3'd0) begin
                        out_io    <= {2'b00, src_byte[7], 1'b0};
                        shift_out <= {src_byte[6:0], 1'b0};
                    end else begin
                        out_io    <= {2'b00, shift_out[7], 1'b0};
                        shift_out <= {shift_out[6:0], 1'b0};
                    end
                    if (state == ST_RDATA && out_cnt == 3'd6) begin
                        out_mem_addr <= out_mem_addr + 1'b1;
                        out_mem_re   <= 1'b1;
                    end
                    out_cnt <= out_cnt + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_spi_flash_responder.sv
// Self-checking bench: acts as the SPI master and the byte-wide memory,
// scoreboarding read data, memory strobes and status against expectations.
module tb_mem_spi_flash_responder;

    localparam int HALF = 8;

    typedef struct packed {
        logic [23:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_cs_n, in_sclk;
    logic [3:0]  in_io;
    logic [3:0]  out_io, out_io_oe;
    logic [23:0] out_mem_addr;
    logic        out_mem_re, out_mem_we;
    logic [7:0]  in_mem_rdata, out_mem_wdata;
    logic [1:0]  out_status;

    logic [7:0]  mem [256];
    int          checks = 0;
    int          errors = 0;
    int          we_cnt = 0;
    int          re_cnt = 0;
    logic        oe_seen = 1'b0;

    logic [23:0] exp_re_q [$];
    logic [7:0]  exp_rd_q [$];
    wr_t         exp_wr_q [$];

    mem_spi_flash_responder #(.ADDR_W(24), .DUMMY_QUAD(8)) dut (
        .clk(clk), .rst(rst), .in_cs_n(in_cs_n), .in_sclk(in_sclk), .in_io(in_io),
        .out_io(out_io), .out_io_oe(out_io_oe), .out_mem_addr(out_mem_addr),
        .out_mem_re(out_mem_re), .in_mem_rdata(in_mem_rdata), .out_mem_we(out_mem_we),
        .out_mem_wdata(out_mem_wdata), .out_status(out_status)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Memory with one-cycle read latency; contents restored on reset.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
            mem[8'h10] <= 8'hA5;
            mem[8'h11] <= 8'h3C;
        end else begin
            if (out_mem_re) in_mem_rdata <= mem[out_mem_addr[7:0]];
            if (out_mem_we) mem[out_mem_addr[7:0]] <= out_mem_wdata;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (out_io_oe != 4'h0) oe_seen <= 1'b1;
            if (out_mem_we) begin
                we_cnt++;
                if (exp_wr_q.size() == 0) begin
                    checkOutput("we_unexpected", 32'(out_mem_addr), 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_wr_q.pop_front();
                    checkOutput("we_addr", 32'(out_mem_addr), 32'(e.addr));
                    checkOutput("we_data", 32'(out_mem_wdata), 32'(e.data));
                end
            end
            if (out_mem_re) begin
                re_cnt++;
                if (exp_re_q.size() > 0)
                    checkOutput("re_addr", 32'(out_mem_addr), 32'(exp_re_q.pop_front()));
            end
        end
    end

    // One SCLK period: present io while low, sample DUT just before rise.
    task automatic applyStimulus(input logic [3:0] io_val, output logic [3:0] io_seen);
        in_io = io_val;
        repeat (HALF) @(posedge clk);
        #1;
        io_seen = out_io & out_io_oe;
        in_sclk = 1'b1;
        repeat (HALF) @(posedge clk);
        #1;
        in_sclk = 1'b0;
    endtask

    task automatic xferSingle(input logic [7:0] tx, output logic [7:0] rx);
        logic [3:0] s;
        for (int i = 7; i >= 0; i--) begin
            applyStimulus({3'b000, tx[i]}, s);
            rx[i] = s[1];
        end
    endtask

    task automatic xferQuad(input logic [7:0] tx, output logic [7:0] rx);
        logic [3:0] s;
        applyStimulus(tx[7:4], s);
        rx[7:4] = s;
        applyStimulus(tx[3:0], s);
        rx[3:0] = s;
    endtask

    task automatic sendByte(input logic [7:0] b);
        logic [7:0] unused_rx;
        xferSingle(b, unused_rx);
    endtask

    task automatic csLow();
        in_cs_n = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic csHigh();
        repeat (6) @(posedge clk);
        #1;
        in_cs_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic simpleCmd(input logic [7:0] op);
        csLow();
        sendByte(op);
        csHigh();
    endtask

    task automatic readStatus(input logic [7:0] op, input logic [7:0] expected);
        logic [7:0] rx;
        exp_rd_q.push_back(expected);
        csLow();
        sendByte(op);
        xferSingle(8'h00, rx);
        checkOutput("status_byte", 32'(rx), 32'(exp_rd_q.pop_front()));
        csHigh();
    endtask

    initial begin
        logic [7:0] rx;
        logic [3:0] s;
        int         snap;

        rst = 1'b1; in_cs_n = 1'b1; in_sclk = 1'b0; in_io = 4'h0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_io", 32'(out_io), 32'h0);
        checkOutput("rst_oe", 32'(out_io_oe), 32'h0);
        checkOutput("rst_re", 32'(out_mem_re), 32'h0);
        checkOutput("rst_we", 32'(out_mem_we), 32'h0);
        checkOutput("rst_addr", 32'(out_mem_addr), 32'h0);
        checkOutput("rst_wdata", 32'(out_mem_wdata), 32'h0);
        checkOutput("rst_status", 32'(out_status), 32'h0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        $display("[TB] WREN / WRDI status");
        simpleCmd(8'h06);
        checkOutput("wel_set", 32'(out_status), 32'h1);
        readStatus(8'h05, 8'h02);
        simpleCmd(8'h04);
        readStatus(8'h05, 8'h00);

        $display("[TB] reset in the middle of a read");
        simpleCmd(8'h06);
        csLow();
        sendByte(8'h03);
        sendByte(8'h00);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("midrst_oe", 32'(out_io_oe), 32'h0);
        checkOutput("midrst_status", 32'(out_status), 32'h0);
        rst = 1'b0;
        in_cs_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        readStatus(8'h05, 8'h00);

        $display("[TB] single read");
        exp_re_q.push_back(24'h000010);
        exp_re_q.push_back(24'h000011);
        exp_rd_q.push_back(8'hA5);
        exp_rd_q.push_back(8'h3C);
        csLow();
        sendByte(8'h03); sendByte(8'h00); sendByte(8'h00); sendByte(8'h10);
        for (int i = 0; i < 2; i++) begin
            xferSingle(8'h00, rx);
            checkOutput("rd_byte", 32'(rx), 32'(exp_rd_q.pop_front()));
        end
        csHigh();
        checkOutput("rd_re_left", 32'(exp_re_q.size()), 32'h0);

        $display("[TB] page program with page wrap");
        simpleCmd(8'h06);
        exp_wr_q.push_back('{addr: 24'h0000FE, data: 8'h11});
        exp_wr_q.push_back('{addr: 24'h0000FF, data: 8'h22});
        exp_wr_q.push_back('{addr: 24'h000000, data: 8'h33});
        csLow();
        sendByte(8'h02); sendByte(8'h00); sendByte(8'h00); sendByte(8'hFE);
        sendByte(8'h11); sendByte(8'h22); sendByte(8'h33);
        csHigh();
        checkOutput("pp_wr_left", 32'(exp_wr_q.size()), 32'h0);
        checkOutput("pp_wel_clr", 32'(out_status), 32'h0);

        $display("[TB] quad read rejected while QE=0");
        oe_seen = 1'b0;
        snap = re_cnt;
        csLow();
        sendByte(8'h6B); sendByte(8'h00); sendByte(8'h00); sendByte(8'h10);
        for (int i = 0; i < 8; i++) applyStimulus(4'h0, s);
        xferQuad(8'h00, rx);
        csHigh();
        checkOutput("noqe_oe", 32'(oe_seen), 32'h0);
        checkOutput("noqe_re", 32'(re_cnt - snap), 32'h0);

        $display("[TB] enable QE and quad read");
        simpleCmd(8'h06);
        csLow();
        sendByte(8'h31); sendByte(8'h02);
        csHigh();
        checkOutput("qe_set", 32'(out_status), 32'h2);
        readStatus(8'h35, 8'h02);
        exp_re_q.push_back(24'h000010);
        exp_re_q.push_back(24'h000011);
        exp_rd_q.push_back(8'hA5);
        exp_rd_q.push_back(8'h3C);
        csLow();
        sendByte(8'h6B); sendByte(8'h00); sendByte(8'h00); sendByte(8'h10);
        for (int i = 0; i < 8; i++) applyStimulus(4'h0, s);
        for (int i = 0; i < 2; i++) begin
            xferQuad(8'h00, rx);
            checkOutput("qrd_byte", 32'(rx), 32'(exp_rd_q.pop_front()));
        end
        checkOutput("qrd_oe", 32'(out_io_oe), 32'hF);
        csHigh();
        checkOutput("qrd_oe_off", 32'(out_io_oe), 32'h0);

        $display("[TB] partial program byte");
        simpleCmd(8'h06);
        snap = we_cnt;
        csLow();
        sendByte(8'h02); sendByte(8'h00); sendByte(8'h00); sendByte(8'h40);
        for (int i = 0; i < 4; i++) applyStimulus(4'h1, s);
        csHigh();
        checkOutput("partial_we", 32'(we_cnt - snap), 32'h0);
        checkOutput("partial_wel", 32'(out_status), 32'h3);

        checkOutput("rd_q_left", 32'(exp_rd_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
